// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter and phase sequencer for cpu15.
// Steps every instruction through FT -> DC -> EX -> WB, one cycle each.
// The phase strobes are taken straight from one-hot state flops, so they are
// glitch-free when used as clock enables. P_COUNT moves only at the edge that
// ends WB, which resolves jmp, je and hlt from the latched instruction.
module pc_sequencer #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 15,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic [INSTR_WIDTH-1:0] PROM_OUT,
    input  logic                   CMP_EQ,
    output logic [PC_WIDTH-1:0]    P_COUNT,
    output logic                   PH_FT,
    output logic                   PH_DC,
    output logic                   PH_EX,
    output logic                   PH_WB,
    output logic                   HALTED,
    output logic [15:0]            INSTR_CNT
);

    // Bit positions inside the one-hot state vector.
    localparam int ST_IDLE = 0;
    localparam int ST_FT   = 1;
    localparam int ST_DC   = 2;
    localparam int ST_EX   = 3;
    localparam int ST_WB   = 4;
    localparam int ST_HALT = 5;

    typedef enum logic [5:0] {
        S_IDLE = 6'b000001,
        S_FT   = 6'b000010,
        S_DC   = 6'b000100,
        S_EX   = 6'b001000,
        S_WB   = 6'b010000,
        S_HALT = 6'b100000
    } state_t;

    localparam logic [3:0] OP_JE  = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t                   state_q;
    state_t                   state_d;
    logic [INSTR_WIDTH-1:0]   ir_q;
    logic [PC_WIDTH-1:0]      pc_q;
    logic [PC_WIDTH-1:0]      pc_next;
    logic [15:0]              cnt_q;
    logic [3:0]               opcode;
    logic [PC_WIDTH-1:0]      target;
    logic                     unused_ir_bits;

    assign opcode = ir_q[INSTR_WIDTH-1 -: 4];
    // Branch targets are 8 bits wide and zero-extended to the PC width.
    assign target = PC_WIDTH'(ir_q[7:0]);
    // Register-field bits of the instruction play no part in sequencing.
    assign unused_ir_bits = ^ir_q[INSTR_WIDTH-5:8];

    // Next-state logic: fixed four-cycle rotation, START honoured only when idle or halted.
    always_comb begin
        // NOTE: state_d gets a default before the case so no path can leave it unassigned and infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (START) state_d = S_FT;
            S_FT:    state_d = S_DC;
            S_DC:    state_d = S_EX;
            S_EX:    state_d = S_WB;
            S_WB:    state_d = (opcode == OP_HLT) ? S_HALT : S_FT;
            S_HALT:  if (START) state_d = S_FT;
            default: state_d = S_IDLE;
        endcase
    end

    // Address of the next instruction, applied at the edge that ends WB.
    always_comb begin
        pc_next = pc_q + PC_WIDTH'(1);
        unique case (opcode)
            OP_JMP:  pc_next = target;
            OP_JE:   if (CMP_EQ) pc_next = target;
            OP_HLT:  pc_next = pc_q;
            default: pc_next = pc_q + PC_WIDTH'(1);
        endcase
    end

    // State register; the phase strobes and HALTED are bits of it.
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Instruction register: captures fetch output only at the end of DC.
    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: IR is reset even though DC always reloads it, so a restarted sequence never decodes stale X.
        if (RESET)                 ir_q <= '0;
        else if (state_q == S_DC)  ir_q <= PROM_OUT;
    end

    // Program counter: held through the instruction, restarted from RESET_PC when leaving HALT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                              pc_q <= RESET_PC;
        else if (state_q == S_WB)               pc_q <= pc_next;
        else if (state_q == S_HALT && START)    pc_q <= RESET_PC;
    end

    // Retired-instruction counter: saturates at all-ones, cleared on restart from HALT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else if (state_q == S_WB) begin
            if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end else if (state_q == S_HALT && START) begin
            cnt_q <= '0;
        end
    end

    assign P_COUNT   = pc_q;
    assign PH_FT     = state_q[ST_FT];
    assign PH_DC     = state_q[ST_DC];
    assign PH_EX     = state_q[ST_EX];
    assign PH_WB     = state_q[ST_WB];
    assign HALTED    = state_q[ST_HALT];
    assign INSTR_CNT = cnt_q;

    // IDLE has its own flop for clarity of the encoding but drives no output.
    logic unused_idle;
    assign unused_idle = state_q[ST_IDLE];

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. Inputs are driven and outputs checked
// on the falling edge, half a cycle away from the active rising edge.
module tb_pc_sequencer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [14:0] PROM_OUT;
    logic        CMP_EQ;
    logic [7:0]  P_COUNT;
    logic        PH_FT, PH_DC, PH_EX, PH_WB;
    logic        HALTED;
    logic [15:0] INSTR_CNT;
    logic [3:0]  ph;

    int tests  = 0;
    int failed = 0;

    localparam logic [14:0] I_MOV    = 15'b000000000000000;
    localparam logic [14:0] I_JMP8   = 15'b110000000001000;
    localparam logic [14:0] I_JMP12  = 15'b110000000001100;
    localparam logic [14:0] I_JMP55  = 15'b110000001010101;
    localparam logic [14:0] I_JE14   = 15'b101100000001110;
    localparam logic [14:0] I_JE12   = 15'b101100000001100;
    localparam logic [14:0] I_HLT    = 15'b111100000000000;

    pc_sequencer dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .PROM_OUT  (PROM_OUT),
        .CMP_EQ    (CMP_EQ),
        .P_COUNT   (P_COUNT),
        .PH_FT     (PH_FT),
        .PH_DC     (PH_DC),
        .PH_EX     (PH_EX),
        .PH_WB     (PH_WB),
        .HALTED    (HALTED),
        .INSTR_CNT (INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    assign ph = {PH_FT, PH_DC, PH_EX, PH_WB};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    // Runs mov instructions until an FT cycle presents the target address.
    task automatic run_to_pc(input logic [7:0] target);
        int n;
        n = 0;
        PROM_OUT = I_MOV;
        while (!(PH_FT === 1'b1 && P_COUNT === target) && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("run_to_pc_bound", 32'(n < 2000), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET    = 1'b1;
        START    = 1'b0;
        PROM_OUT = I_MOV;
        CMP_EQ   = 1'b0;
        step(2);

        // Reset state
        check("rst_pc",     32'(P_COUNT),   32'd0);
        check("rst_ph",     32'(ph),        32'd0);
        check("rst_halted", 32'(HALTED),    32'd0);
        check("rst_cnt",    32'(INSTR_CNT), 32'd0);
        RESET = 1'b0;
        step(3);
        check("idle_no_start_ph", 32'(ph), 32'd0);

        // Test 1: START pulse, three movs with one-hot rotation
        START = 1'b1;
        step(1);
        START = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int p = 0; p < 4; p++) begin
                check($sformatf("t1_ph_i%0d_p%0d", i, p), 32'(ph), 32'(4'b1000 >> p));
                check($sformatf("t1_pc_i%0d_p%0d", i, p), 32'(P_COUNT), 32'(i));
                step(1);
            end
        end
        check("t1_cnt_after_12", 32'(INSTR_CNT), 32'd3);
        check("t1_ft_pc3",       32'(P_COUNT),   32'd3);

        // Test 2: jmp 8 at P_COUNT 13
        run_to_pc(8'd13);
        check("t2_cnt_at13", 32'(INSTR_CNT), 32'd13);
        PROM_OUT = I_JMP8;
        step(4);
        check("t2_ft",  32'(ph),      32'b1000);
        check("t2_pc8", 32'(P_COUNT), 32'd8);

        // Test 3a: je 14 taken at P_COUNT 12
        run_to_pc(8'd12);
        PROM_OUT = I_JE14;
        step(3);
        check("t3a_in_wb", 32'(ph), 32'b0001);
        CMP_EQ = 1'b1;
        step(1);
        CMP_EQ = 1'b0;
        check("t3a_pc14", 32'(P_COUNT), 32'd14);
        check("t3a_cnt",  32'(INSTR_CNT), 32'd19);

        // Back to 12, then je not taken; CMP_EQ high outside WB and PROM_OUT
        // changed after DC must both be ignored.
        PROM_OUT = I_JMP12;
        step(4);
        check("t3b_pc12", 32'(P_COUNT), 32'd12);
        PROM_OUT = I_JE12;
        CMP_EQ   = 1'b1;
        step(2);
        PROM_OUT = I_JMP55;
        step(1);
        CMP_EQ = 1'b0;
        step(1);
        check("t3b_pc13", 32'(P_COUNT), 32'd13);
        check("t3b_ft",   32'(ph),      32'b1000);
        PROM_OUT = I_MOV;
        step(4);
        check("t4_pc14_pre", 32'(P_COUNT),   32'd14);
        check("t4_cnt_pre",  32'(INSTR_CNT), 32'd22);

        // Test 4: hlt at P_COUNT 14, then restart
        PROM_OUT = I_HLT;
        step(4);
        PROM_OUT = I_MOV;
        check("t4_halted", 32'(HALTED),    32'd1);
        check("t4_ph0",    32'(ph),        32'd0);
        check("t4_cnt",    32'(INSTR_CNT), 32'd23);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("t4_hold_pc_%0d", i), 32'(P_COUNT), 32'd14);
            check($sformatf("t4_hold_hlt_%0d", i), 32'({HALTED, ph}), 32'b10000);
            step(1);
        end
        START = 1'b1;
        step(1);
        START = 1'b0;
        check("t4_restart_halted", 32'(HALTED),    32'd0);
        check("t4_restart_ft",     32'(ph),        32'b1000);
        check("t4_restart_pc",     32'(P_COUNT),   32'd0);
        check("t4_restart_cnt",    32'(INSTR_CNT), 32'd0);

        // Test 5: wrap 255 -> 0, then counter saturation
        run_to_pc(8'd255);
        check("t5_cnt255", 32'(INSTR_CNT), 32'd255);
        step(4);
        check("t5_wrap_pc", 32'(P_COUNT), 32'd0);
        check("t5_wrap_ft", 32'(ph),      32'b1000);
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        check("t5_forced", 32'(INSTR_CNT), 32'hFFFF);
        step(4);
        check("t5_sat",   32'(INSTR_CNT), 32'hFFFF);
        check("t5_pc1",   32'(P_COUNT),   32'd1);

        // Test 6a: START during DC has no effect
        step(1);
        START = 1'b1;
        step(1);
        check("t6_ex_ph", 32'(ph),      32'b0010);
        check("t6_ex_pc", 32'(P_COUNT), 32'd1);
        START = 1'b0;
        step(1);
        check("t6_wb_ph", 32'(ph), 32'b0001);
        step(1);
        check("t6_ft_pc2", 32'(P_COUNT), 32'd2);
        check("t6_ft_ph",  32'(ph),      32'b1000);

        // Test 6b: asynchronous reset mid-EX
        step(2);
        check("t6_in_ex", 32'(ph), 32'b0010);
        RESET = 1'b1;
        #1;
        check("t6_rst_pc",     32'(P_COUNT),   32'd0);
        check("t6_rst_ph",     32'(ph),        32'd0);
        check("t6_rst_halted", 32'(HALTED),    32'd0);
        check("t6_rst_cnt",    32'(INSTR_CNT), 32'd0);
        step(1);
        RESET = 1'b0;
        step(3);
        check("t6_idle_ph", 32'(ph),      32'd0);
        check("t6_idle_pc", 32'(P_COUNT), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
